// File: rtl/inst_encoder_loader.sv
// Streaming RV32I encoder/loader: packs decoded field bundles into 32-bit instruction words
// and writes them to instruction memory at an auto-incrementing word address.
module inst_encoder_loader #(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [6:0]            opcode_i,
    input  logic [2:0]            funct3_i,
    input  logic [6:0]            funct7_i,
    input  logic [4:0]            rd_i,
    input  logic [4:0]            rs1_i,
    input  logic [4:0]            rs2_i,
    input  logic [31:0]           imm_i,
    input  logic                  last_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [INST_WIDTH-1:0] mem_wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  err_o,
    output logic [2:0]            dbg_state_o
);

    // Handshake: a bundle is consumed on a rising edge where valid_i and ready_o are both high;
    // ready_o depends only on the FSM state, never on valid_i.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [INST_WIDTH-1:0] r_word;
    logic                  r_last;

    logic [INST_WIDTH-1:0] w_word;
    logic                  w_legal;

    always_comb begin
        w_word  = '0;
        w_legal = 1'b1;
        case (opcode_i)
            OP_R:
                w_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            OP_IMM: begin
                // Shift-immediates carry funct7 in the upper immediate bits
                if (funct3_i == 3'b001 || funct3_i == 3'b101)
                    w_word = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
                else
                    w_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            end
            OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM:
                w_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            OP_STORE:
                w_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            OP_BRANCH: begin
                w_word  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                           imm_i[4:1], imm_i[11], opcode_i};
                w_legal = ~imm_i[0];
            end
            OP_LUI, OP_AUIPC:
                w_word = {imm_i[31:12], rd_i, opcode_i};
            OP_JAL: begin
                w_word  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                w_legal = ~imm_i[0];
            end
            default:
                w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_count <= '0;
            r_word  <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ERROR: begin
                    if (start_i) begin
                        r_state <= S_LOAD;
                        r_ptr   <= base_addr_i;
                        r_count <= '0;
                    end
                end
                S_LOAD: begin
                    if (valid_i) begin
                        if (w_legal) begin
                            r_word  <= w_word;
                            r_last  <= last_i;
                            r_state <= S_WRITE;
                        end else begin
                            r_state <= S_ERROR;
                        end
                    end
                end
                S_WRITE: begin
                    r_count <= r_count + (ADDR_WIDTH+1)'(1);
                    // The pointer saturates at the top word so it never wraps to 0
                    if (r_ptr != LAST_ADDR)
                        r_ptr <= r_ptr + ADDR_WIDTH'(1);
                    if (r_last)
                        r_state <= S_DONE;
                    else if (r_ptr == LAST_ADDR)
                        r_state <= S_ERROR;
                    else
                        r_state <= S_LOAD;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready_o     = (r_state == S_LOAD);
    assign mem_we_o    = (r_state == S_WRITE);
    assign mem_addr_o  = r_ptr;
    assign mem_wdata_o = r_word;
    assign busy_o      = (r_state == S_LOAD) || (r_state == S_WRITE);
    assign done_o      = (r_state == S_DONE);
    assign count_o     = r_count;
    assign err_o       = (r_state == S_ERROR);
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Randomized and directed bench for inst_encoder_loader with a field-level encoding model.
module tb_inst_encoder_loader;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [9:0]  base_addr_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [6:0]  opcode_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [6:0]  funct7_i = '0;
    logic [4:0]  rd_i = '0;
    logic [4:0]  rs1_i = '0;
    logic [4:0]  rs2_i = '0;
    logic [31:0] imm_i = '0;
    logic        last_i = 1'b0;
    logic        mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        busy_o;
    logic        done_o;
    logic [10:0] count_o;
    logic        err_o;
    logic [2:0]  dbg_state_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [41:0] exp_q[$];

    inst_encoder_loader dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
        .valid_i(valid_i), .ready_o(ready_o), .opcode_i(opcode_i), .funct3_i(funct3_i),
        .funct7_i(funct7_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
        .last_i(last_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .busy_o(busy_o), .done_o(done_o), .count_o(count_o),
        .err_o(err_o), .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference model: field placement by arithmetic on the instruction format tables
    function automatic logic [31:0] ref_encode(input logic [6:0] op, input logic [2:0] f3,
                                               input logic [6:0] f7, input logic [4:0] rd,
                                               input logic [4:0] rs1, input logic [4:0] rs2,
                                               input logic [31:0] imm);
        logic [31:0] base_i, base_rs;
        base_i  = (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
        base_rs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        case (op)
            7'h33: return (32'(f7) << 25) | base_rs | (32'(rd) << 7);
            7'h13: if (f3 == 3'd1 || f3 == 3'd5)
                       return (32'(f7) << 25) | ((imm & 32'h1F) << 20) | base_i;
                   else
                       return ((imm & 32'hFFF) << 20) | base_i;
            7'h03, 7'h67, 7'h0F, 7'h73: return ((imm & 32'hFFF) << 20) | base_i;
            7'h23: return (((imm >> 5) & 32'h7F) << 25) | base_rs | ((imm & 32'h1F) << 7);
            7'h63: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | base_rs
                        | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
            7'h37, 7'h17: return (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
            7'h6F: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                        | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                        | (32'(rd) << 7) | 32'(op);
            default: return 32'h0;
        endcase
    endfunction

    // scoreboard: every write strobe must match the head of the expected queue
    always @(negedge clk_i) begin
        if (rst_ni && mem_we_o) begin
            logic [41:0] e;
            check_eq("ready_low_in_write", ready_o, 0);
            if (exp_q.size() == 0) begin
                check_eq("write_unexpected", mem_we_o, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("write_addr", mem_addr_o, e[41:32]);
                check_eq("write_data", mem_wdata_o, e[31:0]);
            end
        end
    end

    // drivers
    task automatic start_session(input logic [9:0] base);
        @(negedge clk_i);
        start_i = 1'b1;
        base_addr_i = base;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic send_op(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm, input logic last);
        int t;
        @(negedge clk_i);
        opcode_i = op; funct3_i = f3; funct7_i = f7; rd_i = rd;
        rs1_i = rs1; rs2_i = rs2; imm_i = imm; last_i = last;
        valid_i = 1'b1;
        t = 0;
        while (!ready_o && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        if (!ready_o) begin
            check_eq("ready_timeout", ready_o, 1);
        end else begin
            @(posedge clk_i);
            #1;
        end
        valid_i = 1'b0;
        last_i = 1'b0;
    endtask

    task automatic wait_done(input int exp_count);
        int t;
        t = 0;
        @(negedge clk_i);
        while (!done_o && t < 10) begin
            @(negedge clk_i);
            t++;
        end
        check_eq("done_pulse", done_o, 1);
        check_eq("done_count", count_o, 64'(exp_count));
        check_eq("done_busy", busy_o, 0);
        @(negedge clk_i);
        check_eq("done_one_cycle", done_o, 0);
    endtask

    task automatic push_exp(input logic [9:0] addr, input logic [31:0] word);
        exp_q.push_back({addr, word});
    endtask

    logic [6:0] legal_ops[10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h73,
                                  7'h23, 7'h63, 7'h37, 7'h6F};

    initial begin
        int n;
        logic [9:0] base;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] rd, rs1, rs2;
        logic [31:0] imm;

        repeat (3) @(negedge clk_i);
        check_eq("rst_ready", ready_o, 0);
        check_eq("rst_we", mem_we_o, 0);
        check_eq("rst_addr", mem_addr_o, 0);
        check_eq("rst_wdata", mem_wdata_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_count", count_o, 0);
        check_eq("rst_err", err_o, 0);
        rst_ni = 1'b1;

        // addi x1,x0,5
        start_session(10'd0);
        check_eq("load_busy", busy_o, 1);
        push_exp(10'd0, 32'h00500093);
        send_op(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        wait_done(1);

        // add / sub
        start_session(10'd0);
        push_exp(10'd0, 32'h002081B3);
        push_exp(10'd1, 32'h402081B3);
        send_op(7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        send_op(7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        wait_done(2);

        // sw, beq, jal
        start_session(10'd10);
        push_exp(10'd10, 32'h0020A423);
        push_exp(10'd11, 32'hFE208EE3);
        push_exp(10'd12, 32'h008000EF);
        send_op(7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        send_op(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0);
        send_op(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1);
        wait_done(3);

        // lui (low imm bits dropped), srai
        start_session(10'd20);
        push_exp(10'd20, 32'h123452B7);
        push_exp(10'd21, 32'h4030D093);
        send_op(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345ABC, 1'b0);
        send_op(7'h13, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 32'd3, 1'b1);
        wait_done(2);

        // illegal opcode -> sticky error, no write
        start_session(10'd5);
        send_op(7'h7F, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
        @(negedge clk_i);
        check_eq("illegal_err", err_o, 1);
        check_eq("illegal_ready", ready_o, 0);
        check_eq("illegal_busy", busy_o, 0);
        check_eq("illegal_count", count_o, 0);
        repeat (3) @(negedge clk_i);
        check_eq("err_sticky", err_o, 1);
        start_session(10'd7);
        check_eq("restart_err_clr", err_o, 0);
        check_eq("restart_ready", ready_o, 1);

        // misaligned branch -> error, then recover
        send_op(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
        @(negedge clk_i);
        check_eq("misaligned_err", err_o, 1);
        start_session(10'd7);
        push_exp(10'd7, 32'h00500093);
        send_op(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        wait_done(1);

        // overflow at top word: written, then error instead of next load
        start_session(10'd1023);
        push_exp(10'd1023, 32'h00500093);
        send_op(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        check_eq("ovf_err", err_o, 1);
        check_eq("ovf_count", count_o, 1);
        check_eq("ovf_ready", ready_o, 0);

        // randomized sessions
        for (int s = 0; s < 8; s++) begin
            n = $urandom_range(1, 8);
            base = 10'($urandom_range(0, 1000));
            start_session(base);
            for (int i = 0; i < n; i++) begin
                op  = legal_ops[$urandom_range(0, 9)];
                f3  = 3'($urandom_range(0, 7));
                f7  = 7'($urandom_range(0, 127));
                rd  = 5'($urandom_range(0, 31));
                rs1 = 5'($urandom_range(0, 31));
                rs2 = 5'($urandom_range(0, 31));
                imm = $urandom;
                if (op == 7'h63 || op == 7'h6F) imm[0] = 1'b0;
                push_exp(base + 10'(i), ref_encode(op, f3, f7, rd, rs1, rs2, imm));
                send_op(op, f3, f7, rd, rs1, rs2, imm, (i == n - 1));
            end
            wait_done(n);
        end

        // async reset during a write: outputs drop immediately, write lost
        start_session(10'd100);
        send_op(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        check_eq("pre_rst_we", mem_we_o, 1);
        check_eq("pre_rst_addr", mem_addr_o, 100);
        rst_ni = 1'b0;
        #1;
        check_eq("async_we", mem_we_o, 0);
        check_eq("async_addr", mem_addr_o, 0);
        check_eq("async_wdata", mem_wdata_o, 0);
        check_eq("async_busy", busy_o, 0);
        check_eq("async_ready", ready_o, 0);
        check_eq("async_done", done_o, 0);
        check_eq("async_err", err_o, 0);
        check_eq("async_count", count_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        check_eq("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
